// File: rtl/duty_slew_pkg.sv
// Shared types and constants for the duty_slew rate limiter.
// Optional build macro: DUTY_SLEW_ESTOP_EN (adds an emergency-stop input).
package duty_slew_pkg;

    localparam int DUTY_W   = 12;
    localparam int DIFF_W   = DUTY_W + 1;
    localparam int DUTY_MAX = 2047;
    localparam int DUTY_MIN = -2047;

    typedef enum logic [1:0] {
        TRACK,
        TO_ZERO,
        HOLD
    } slew_state_t;

    typedef logic signed [DUTY_W-1:0] duty_t;
    typedef logic signed [DIFF_W-1:0] diff_t;

    // The driver magnitude is 11 bits, so the one unrepresentable value
    // (-2048) is pulled in to the symmetric limit.
    function automatic duty_t clamp_duty(input duty_t v);
        duty_t r;
        r = v;
        if (v < duty_t'(DUTY_MIN)) begin
            r = duty_t'(DUTY_MIN);
        end
        return r;
    endfunction

endpackage

// File: rtl/duty_slew_ch.sv
// One duty channel: target clamp, reversal FSM, zero-dwell counter and
// the registered duty output.
// Optional build macro: DUTY_SLEW_ESTOP_EN (adds estop_i).
module duty_slew_ch
    import duty_slew_pkg::*;
#(
    parameter int STEP      = 8,
    parameter int ZERO_HOLD = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  tick_i,
`ifdef DUTY_SLEW_ESTOP_EN
    input  logic  estop_i,
`endif
    input  duty_t tgt_i,
    output duty_t duty_o,
    output logic  at_tgt_o
);

    localparam int    HC_W   = (ZERO_HOLD > 1) ? $clog2(ZERO_HOLD) : 1;
    localparam diff_t STEP_D = diff_t'(STEP);

    slew_state_t      state_q, state_d;
    duty_t            duty_q, duty_d;
    logic [HC_W-1:0]  hold_q, hold_d;

    duty_t tgt_c;
    diff_t duty_x, tgt_x;
    diff_t trk_diff, trk_lim, trk_sum;
    diff_t zro_diff, zro_lim, zro_sum;
    duty_t track_duty, zero_duty;
    logic  reversal, same_sign;

    // Step arithmetic in 13 bits so target-duty differences never wrap.
    always_comb begin
        tgt_c    = clamp_duty(tgt_i);
        duty_x   = {duty_q[DUTY_W-1], duty_q};
        tgt_x    = {tgt_c[DUTY_W-1], tgt_c};

        trk_diff = tgt_x - duty_x;
        if (trk_diff > STEP_D) begin
            trk_lim = STEP_D;
        end else if (trk_diff < -STEP_D) begin
            trk_lim = -STEP_D;
        end else begin
            trk_lim = trk_diff;
        end
        trk_sum    = duty_x + trk_lim;
        track_duty = trk_sum[DUTY_W-1:0];

        zro_diff = -duty_x;
        if (zro_diff > STEP_D) begin
            zro_lim = STEP_D;
        end else if (zro_diff < -STEP_D) begin
            zro_lim = -STEP_D;
        end else begin
            zro_lim = zro_diff;
        end
        zro_sum   = duty_x + zro_lim;
        zero_duty = zro_sum[DUTY_W-1:0];

        reversal  = (duty_q != '0) && (tgt_c != '0) && (tgt_c[DUTY_W-1] != duty_q[DUTY_W-1]);
        same_sign = (duty_q != '0) && (tgt_c != '0) && (tgt_c[DUTY_W-1] == duty_q[DUTY_W-1]);
    end

    // Next-state logic; the FSM only moves on ramp ticks.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        if (tick_i) begin
            case (state_q)
                TRACK: begin
                    if (reversal) begin
                        duty_d = zero_duty;
                        if (zero_duty == '0) begin
                            state_d = HOLD;
                            hold_d  = '0;
                        end else begin
                            state_d = TO_ZERO;
                        end
                    end else begin
                        duty_d = track_duty;
                    end
                end
                TO_ZERO: begin
                    if (same_sign) begin
                        state_d = TRACK;
                        duty_d  = track_duty;
                    end else begin
                        duty_d = zero_duty;
                        if (zero_duty == '0) begin
                            state_d = HOLD;
                            hold_d  = '0;
                        end
                    end
                end
                HOLD: begin
                    duty_d = '0;
                    if (hold_q == HC_W'(ZERO_HOLD - 1)) begin
                        state_d = TRACK;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HC_W'(1);
                    end
                end
                default: begin
                    state_d = TRACK;
                    duty_d  = '0;
                    hold_d  = '0;
                end
            endcase
        end
`ifdef DUTY_SLEW_ESTOP_EN
        // Emergency stop wins over everything and restarts the full dwell.
        if (estop_i) begin
            state_d = HOLD;
            duty_d  = '0;
            hold_d  = '0;
        end
`endif
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TRACK;
            duty_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
        end
    end

    assign duty_o   = duty_q;
    assign at_tgt_o = (state_q == TRACK) && (duty_q == tgt_c);

endmodule

// File: rtl/duty_slew.sv
// Slew-rate limiter feeding the motor driver: owns the ramp tick, the
// enable masking and the settled flag; two identical channels do the rest.
// Optional build macro: DUTY_SLEW_ESTOP_EN (adds the estop input).
module duty_slew
    import duty_slew_pkg::*;
#(
    parameter int STEP      = 8,
    parameter int TICK_DIV  = 1024,
    parameter int ZERO_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
`ifdef DUTY_SLEW_ESTOP_EN
    input  logic              estop,
`endif
    input  logic [DUTY_W-1:0] lft_tgt,
    input  logic [DUTY_W-1:0] rght_tgt,
    output logic [DUTY_W-1:0] lft_duty,
    output logic [DUTY_W-1:0] rght_duty,
    output logic              settled
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    duty_t tgt_raw [2];
    duty_t tgt_eff [2];
    duty_t duty    [2];
    logic  at_tgt  [2];

    // Ramp-tick divider: tick is high for the last count of each period.
    always_comb begin
        tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Tick counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tgt_raw[0] = lft_tgt;
    assign tgt_raw[1] = rght_tgt;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        // Disabled channels ramp toward a zero target.
        assign tgt_eff[gi] = en ? tgt_raw[gi] : '0;

        duty_slew_ch #(
            .STEP      (STEP),
            .ZERO_HOLD (ZERO_HOLD)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick_i   (tick),
`ifdef DUTY_SLEW_ESTOP_EN
            .estop_i  (estop),
`endif
            .tgt_i    (tgt_eff[gi]),
            .duty_o   (duty[gi]),
            .at_tgt_o (at_tgt[gi])
        );
    end

    assign lft_duty  = duty[0];
    assign rght_duty = duty[1];

`ifdef DUTY_SLEW_ESTOP_EN
    assign settled = at_tgt[0] & at_tgt[1] & ~estop;
`else
    assign settled = at_tgt[0] & at_tgt[1];
`endif

endmodule

// File: tb/tb_duty_slew.sv
// Scoreboard bench for duty_slew (TICK_DIV=4, STEP=8, ZERO_HOLD=4).
// Stimulus pushes the hand-computed post-tick outputs; the monitor pops one
// entry at every output-update edge and compares.
// Optional build macro: DUTY_SLEW_ESTOP_EN enables the estop scenario.
module tb_duty_slew;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic signed [11:0] lft_tgt  = '0;
    logic signed [11:0] rght_tgt = '0;
    logic signed [11:0] lft_duty;
    logic signed [11:0] rght_duty;
    logic               settled;
`ifdef DUTY_SLEW_ESTOP_EN
    logic               estop = 1'b0;
`endif

    typedef struct {
        int l;
        int r;
        int s;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edges;
    int   n_tick  = 0;

    always #5 clk = ~clk;

    duty_slew #(
        .STEP      (8),
        .TICK_DIV  (TD),
        .ZERO_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
`ifdef DUTY_SLEW_ESTOP_EN
        .estop     (estop),
`endif
        .lft_tgt   (lft_tgt),
        .rght_tgt  (rght_tgt),
        .lft_duty  (lft_duty),
        .rght_duty (rght_duty),
        .settled   (settled)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Clock edges since reset release: outputs update on every 4th edge.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    // Monitor: one scoreboard entry per output update.
    always @(negedge clk) begin
        if (!rst && edges > 0 && (edges % TD) == 0 && sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_tick++;
            $display("[TB] tick %0d: lft=%0d/%0d rght=%0d/%0d settled=%0d/%0d",
                     n_tick, lft_duty, mon_e.l, rght_duty, mon_e.r, settled, mon_e.s);
            chk("lft_duty",  int'(lft_duty),  mon_e.l);
            chk("rght_duty", int'(rght_duty), mon_e.r);
            chk("settled",   int'(settled),   mon_e.s);
        end
    end

    // Called at negedge+2 after an update; returns at negedge+2 after the next.
    task automatic expect_tick(input int l, input int r, input int s);
        sb.push_back('{l, r, s});
        repeat (TD) @(negedge clk);
        #2;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int l;
        int r;

        // Reset state
        #12;
        chk("rst_lft",     int'(lft_duty),  0);
        chk("rst_rght",    int'(rght_duty), 0);
        chk("rst_settled", int'(settled),   1);
        @(negedge clk);
        rst = 1'b0;
        #2;
        expect_tick(0, 0, 1);
        expect_tick(0, 0, 1);

        // Reset again, then release with a target waiting: first tick timing
        rst = 1'b1;
        #1;
        chk("rst2_lft",     int'(lft_duty), 0);
        chk("rst2_settled", int'(settled),  1);
        lft_tgt = 12'sd100;
        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{8, 0, 0});
        repeat (TD - 1) @(negedge clk);
        chk("before_first_tick", int'(lft_duty), 0);
        @(negedge clk);
        #2;

        // Ramp 0 -> 100
        for (int i = 2; i <= 13; i++) begin
            v = (8 * i > 100) ? 100 : 8 * i;
            expect_tick(v, 0, (i == 13) ? 1 : 0);
        end

        // Same-sign ramp down to 16
        lft_tgt = 12'sd16;
        v = 100;
        while (v != 16) begin
            v = (v - 8 < 16) ? 16 : v - 8;
            expect_tick(v, 0, (v == 16) ? 1 : 0);
        end

        // Reversal 16 -> -16 with zero dwell
        lft_tgt = -12'sd16;
        expect_tick(8, 0, 0);
        expect_tick(0, 0, 0);
        for (int i = 0; i < 4; i++) expect_tick(0, 0, 0);
        expect_tick(-8, 0, 0);
        expect_tick(-16, 0, 1);

        // -2048 target clamps to -2047
        rght_tgt = -12'sd2048;
        for (int i = 1; i <= 258; i++) begin
            r = (-8 * i < -2047) ? -2047 : -8 * i;
            expect_tick(-16, r, (r == -2047) ? 1 : 0);
        end

        // Left reverses to +40 while right ramps up to -40
        lft_tgt  = 12'sd40;
        rght_tgt = -12'sd40;
        for (int i = 1; i <= 251; i++) begin
            if (i == 1)      l = -8;
            else if (i <= 6) l = 0;
            else             l = (8 * (i - 6) > 40) ? 40 : 8 * (i - 6);
            r = (-2047 + 8 * i > -40) ? -40 : -2047 + 8 * i;
            expect_tick(l, r, (i == 251) ? 1 : 0);
        end

        // en dropped: plain ramp to zero, no dwell
        en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            expect_tick(40 - 8 * i, -40 + 8 * i, (i == 5) ? 1 : 0);
        end

        // Re-enable, then reset mid-ramp
        en = 1'b1;
        expect_tick(8, -8, 0);
        expect_tick(16, -16, 0);
        #1;
        rst = 1'b1;
        #1;
        chk("midramp_rst_lft",  int'(lft_duty),  0);
        chk("midramp_rst_rght", int'(rght_duty), 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        expect_tick(8, -8, 0);

`ifdef DUTY_SLEW_ESTOP_EN
        // Estop at duty 200: immediate zero, full dwell, then ramp resumes
        lft_tgt  = 12'sd200;
        rght_tgt = 12'sd0;
        for (int i = 1; i <= 24; i++) begin
            expect_tick(8 + 8 * i, 0, (i == 24) ? 1 : 0);
        end
        estop = 1'b1;
        @(negedge clk);
        chk("estop_lft",     int'(lft_duty), 0);
        chk("estop_settled", int'(settled),  0);
        estop = 1'b0;
        sb.push_back('{0, 0, 0});
        repeat (TD - 1) @(negedge clk);
        #2;
        for (int i = 0; i < 3; i++) expect_tick(0, 0, 0);
        expect_tick(8, 0, 0);
        expect_tick(16, 0, 0);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
